eic_dispatch: RTL

EIC_DISPATCH -- requirements
Module: eic_dispatch

---
 rtl/eic_pkg.sv | 15 +
 rtl/eic_prio_enc.sv | 25 ++
 rtl/eic_dispatch.sv | 118 +++++++++++
 3 files changed

// File: rtl/eic_pkg.sv
// Shared definitions for the EIC dispatch block: FSM encoding, channel index
// width and the handler offset shift.
package eic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  // Wide enough for any legal channel index (CHANNELS <= 62).
  localparam int CH_IDX_W     = 6;
  localparam int OFFSET_SHIFT = 4;

endpackage

// File: rtl/eic_prio_enc.sv
// Highest-set-bit encoder: reports the index of the most significant set bit
// and whether any bit is set at all.
module eic_prio_enc
  import eic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]    bits,
  output logic [CH_IDX_W-1:0] idx,
  output logic                valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bits[i]) begin
        idx   = CH_IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eic_dispatch.sv
// External interrupt controller dispatch: arbitrates pending channels above the
// current in-service level, presents one request to the CPU and tracks nesting.
module eic_dispatch
  import eic_pkg::*;
#(
  parameter int          CHANNELS   = 16,
  parameter logic [3:0]  SHADOW_SET = 4'd0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] irq_pending,
  input  logic                EIC_IAck,
  input  logic                eoi,
  output logic [7:0]          EIC_Interrupt,
  output logic [5:0]          EIC_Vector,
  output logic [17:1]         EIC_Offset,
  output logic [3:0]          EIC_ShadowSet,
  output logic [CHANNELS-1:0] irq_clear,
  output logic [CHANNELS-1:0] in_service
);

  state_t              state, state_next;
  logic [CH_IDX_W-1:0] chan, chan_next;
  logic [CHANNELS-1:0] isr_next, clear_next;
  logic [CHANNELS-1:0] chan_hot, hi_hot, above_hi, eligible;
  logic [CH_IDX_W-1:0] cand_idx, hi_idx;
  logic                cand_valid, hi_valid, accept;
  logic [16:0]         chan_p1;

  eic_prio_enc #(.WIDTH(CHANNELS)) u_hi_enc (
    .bits  (in_service),
    .idx   (hi_idx),
    .valid (hi_valid)
  );

  eic_prio_enc #(.WIDTH(CHANNELS)) u_cand_enc (
    .bits  (eligible),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  // Decoded masks avoid variable bit-selects whose index is wider than CHANNELS needs.
  always_comb begin
    chan_hot = '0;
    hi_hot   = '0;
    above_hi = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      chan_hot[i] = (chan == CH_IDX_W'(i));
      hi_hot[i]   = hi_valid && (hi_idx == CH_IDX_W'(i));
      above_hi[i] = !hi_valid || (CH_IDX_W'(i) > hi_idx);
    end
  end

  assign eligible = irq_pending & ~in_service & above_hi;

  always_comb begin
    state_next = state;
    chan_next  = chan;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cand_valid) begin
          chan_next  = cand_idx;
          state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (EIC_IAck) begin
          accept     = 1'b1;
          state_next = ST_ACK;
        end else if (cand_valid && (cand_idx > chan)) begin
          chan_next = cand_idx;
        end else if ((irq_pending & chan_hot) == '0) begin
          state_next = ST_IDLE;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // End-of-interrupt retires the pre-ack top level before the new ack bit lands.
  always_comb begin
    isr_next = in_service & ~(eoi ? hi_hot : '0);
    if (accept) isr_next = isr_next | chan_hot;
    clear_next = accept ? chan_hot : '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      state      <= ST_IDLE;
      chan       <= '0;
      in_service <= '0;
      irq_clear  <= '0;
    end else begin
      state      <= state_next;
      chan       <= chan_next;
      in_service <= isr_next;
      irq_clear  <= clear_next;
    end
  end

  assign chan_p1 = 17'(chan) + 17'd1;

  always_comb begin
    EIC_Interrupt = '0;
    EIC_Vector    = '0;
    EIC_Offset    = '0;
    EIC_ShadowSet = SHADOW_SET;
    if (state == ST_PRESENT) begin
      EIC_Interrupt = 8'(chan) + 8'd1;
      EIC_Vector    = chan + 6'd1;
      EIC_Offset    = chan_p1 << OFFSET_SHIFT;
    end
  end

endmodule
